// File: rtl/rr_stats_pkg.sv
// Shared types and constants for the rr_stats heart-rate/RR-history block.
// Build option RR_STATS_OUTLIER_REJECT_EN is consumed in rr_stats.sv.
package rr_stats_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } rr_state_e;

  localparam int BPM_WIDTH = 8;
  localparam int BPM_MAX   = 255;

  // Samples-per-minute numerator: bpm = (60 * fs) / rr_period.
  function automatic int hr_numerator(input int fs_hz);
    return 60 * fs_hz;
  endfunction

  function automatic int hist_ptr_width(input int nhist);
    return (nhist > 1) ? $clog2(nhist) : 1;
  endfunction

  function automatic int hist_sum_width(input int ctr_width, input int nhist);
    return ctr_width + hist_ptr_width(nhist);
  endfunction

endpackage

// File: rtl/rr_stats_div.sv
// Serial restoring divider: one quotient bit per enabled clock, MSB first.
// o_done is high during the final iteration; o_quotient is final after that edge.
module rr_serial_div
  import rr_stats_pkg::*;
#(
  parameter int NUM_WIDTH = 16,
  parameter int DEN_WIDTH = 22
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ce,
  input  logic                 i_start,
  input  logic [NUM_WIDTH-1:0] i_dividend,
  input  logic [DEN_WIDTH-1:0] i_divisor,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [NUM_WIDTH-1:0] o_quotient
);

  localparam int CNT_W = (NUM_WIDTH > 1) ? $clog2(NUM_WIDTH) : 1;

  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_WIDTH-1:0] num_q, num_d;
  logic [DEN_WIDTH-1:0] den_q, den_d;
  logic [DEN_WIDTH-1:0] rem_q, rem_d;
  logic [NUM_WIDTH-1:0] quo_q, quo_d;

  logic [DEN_WIDTH:0]   rem_shift;
  logic [DEN_WIDTH-1:0] rem_diff;
  logic                 fits;

  // NOTE: every variable gets a default before any branch so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    den_d     = den_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    rem_shift = {rem_q, num_q[NUM_WIDTH-1]};
    fits      = (rem_shift >= {1'b0, den_q});
    rem_diff  = rem_shift[DEN_WIDTH-1:0] - den_q;

    if (i_ce) begin
      if (i_start) begin
        busy_d = 1'b1;
        cnt_d  = CNT_W'(NUM_WIDTH - 1);
        num_d  = i_dividend;
        den_d  = i_divisor;
        rem_d  = '0;
        quo_d  = '0;
      end else if (busy_q) begin
        rem_d = fits ? rem_diff : rem_shift[DEN_WIDTH-1:0];
        quo_d = {quo_q[NUM_WIDTH-2:0], fits};
        num_d = {num_q[NUM_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) busy_d = 1'b0;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      num_q  <= '0;
      den_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      num_q  <= num_d;
      den_q  <= den_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = busy_q && (cnt_q == '0);
  assign o_quotient = quo_q;

endmodule

// File: rtl/rr_stats.sv
// Heart rate (BPM) from each RR period plus a running-average RR history.
// Optional build macro RR_STATS_OUTLIER_REJECT_EN keeps outliers out of the history.
module rr_stats
  import rr_stats_pkg::*;
#(
  parameter int CTR_WIDTH = 22,
  parameter int FS_HZ     = 360,
  parameter int NUM_WIDTH = 16,
  parameter int NHIST     = 8,
  parameter int BRADY_BPM = 40,
  parameter int TACHY_BPM = 120
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ce,
  input  logic [CTR_WIDTH-1:0] i_rr_period,
  input  logic                 i_rr_period_updated,
  output logic [BPM_WIDTH-1:0] o_hr_bpm,
  output logic                 o_hr_valid,
  output logic [CTR_WIDTH-1:0] o_rr_avg,
  output logic                 o_rr_avg_valid,
  output logic                 o_brady,
  output logic                 o_tachy,
  output logic                 o_busy,
  output logic                 o_dropped
`ifdef RR_STATS_OUTLIER_REJECT_EN
  ,output logic                o_outlier
`endif
);

  localparam int PTR_W = hist_ptr_width(NHIST);
  localparam int SUM_W = hist_sum_width(CTR_WIDTH, NHIST);

  localparam logic [NUM_WIDTH-1:0] NUMERATOR = NUM_WIDTH'(hr_numerator(FS_HZ));
  localparam logic [BPM_WIDTH-1:0] BPM_MAX_L = BPM_WIDTH'(BPM_MAX);
  localparam logic [BPM_WIDTH-1:0] BRADY_L   = BPM_WIDTH'(BRADY_BPM);
  localparam logic [BPM_WIDTH-1:0] TACHY_L   = BPM_WIDTH'(TACHY_BPM);
  localparam logic [PTR_W:0]       FILL_FULL = (PTR_W + 1)'(NHIST);

  rr_state_e            state_q, state_d;
  logic                 div_zero_q, div_zero_d;
  logic [BPM_WIDTH-1:0] hr_bpm_q, hr_bpm_d;
  logic                 hr_valid_q, hr_valid_d;
  logic                 brady_q, brady_d;
  logic                 tachy_q, tachy_d;
  logic                 dropped_q, dropped_d;

  logic [CTR_WIDTH-1:0] hist_q [NHIST];
  logic [CTR_WIDTH-1:0] hist_d [NHIST];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]       fill_q, fill_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [CTR_WIDTH-1:0] avg_q, avg_d;
  logic                 avg_valid_q, avg_valid_d;
`ifdef RR_STATS_OUTLIER_REJECT_EN
  logic                 outlier_q, outlier_d;
`endif

  logic                 div_start;
  logic                 div_busy;
  logic                 div_done;
  logic [NUM_WIDTH-1:0] div_quotient;
  logic [BPM_WIDTH-1:0] bpm_sat;
  logic                 is_outlier;
  logic                 hist_full;
  logic                 hist_we;
  logic [CTR_WIDTH-1:0] oldest;

  rr_serial_div #(
    .NUM_WIDTH (NUM_WIDTH),
    .DEN_WIDTH (CTR_WIDTH)
  ) u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ce       (i_ce),
    .i_start    (div_start),
    .i_dividend (NUMERATOR),
    .i_divisor  (i_rr_period),
    .o_busy     (div_busy),
    .o_done     (div_done),
    .o_quotient (div_quotient)
  );

  // Control FSM: accept in IDLE, wait out the divider, publish in DONE.
  always_comb begin
    state_d    = state_q;
    div_zero_d = div_zero_q;
    hr_bpm_d   = hr_bpm_q;
    hr_valid_d = hr_valid_q;
    brady_d    = brady_q;
    tachy_d    = tachy_q;
    dropped_d  = dropped_q;
    div_start  = 1'b0;
    bpm_sat    = (div_quotient > NUM_WIDTH'(BPM_MAX)) ? BPM_MAX_L
                                                      : div_quotient[BPM_WIDTH-1:0];

    if (i_ce) begin
      hr_valid_d = 1'b0;
      dropped_d  = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_rr_period_updated) begin
            div_start  = 1'b1;
            div_zero_d = (i_rr_period == '0);
            state_d    = ST_DIV;
          end
        end
        ST_DIV: begin
          if (div_done) state_d = ST_DONE;
        end
        ST_DONE: begin
          // A zero divisor still runs the full divide so latency stays fixed.
          hr_bpm_d   = div_zero_q ? BPM_MAX_L : bpm_sat;
          brady_d    = (hr_bpm_d < BRADY_L);
          tachy_d    = (hr_bpm_d > TACHY_L);
          hr_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (i_rr_period_updated && (state_q != ST_IDLE)) dropped_d = 1'b1;
    end
  end

  // History ring and running sum; dropped updates are still recorded.
  always_comb begin
    hist_d      = hist_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    sum_d       = sum_q;
    avg_d       = avg_q;
    avg_valid_d = avg_valid_q;
    hist_full   = (fill_q == FILL_FULL);
    oldest      = hist_full ? hist_q[wr_ptr_q] : '0;
`ifdef RR_STATS_OUTLIER_REJECT_EN
    is_outlier  = avg_valid_q &&
                  (({1'b0, i_rr_period} > {avg_q, 1'b0}) || (i_rr_period < (avg_q >> 1)));
    outlier_d   = outlier_q;
    if (i_ce) outlier_d = i_rr_period_updated && is_outlier;
`else
    is_outlier  = 1'b0;
`endif
    hist_we     = i_ce && i_rr_period_updated && !is_outlier;

    if (hist_we) begin
      hist_d[wr_ptr_q] = i_rr_period;
      wr_ptr_d         = wr_ptr_q + 1'b1;
      if (!hist_full) fill_d = fill_q + 1'b1;
      sum_d            = sum_q + SUM_W'(i_rr_period) - SUM_W'(oldest);
      avg_d            = sum_d[SUM_W-1:PTR_W];
      avg_valid_d      = (fill_d == FILL_FULL);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      div_zero_q  <= 1'b0;
      hr_bpm_q    <= '0;
      hr_valid_q  <= 1'b0;
      brady_q     <= 1'b0;
      tachy_q     <= 1'b0;
      dropped_q   <= 1'b0;
      // NOTE: the history is a handful of registers, so it is cleared on reset
      // like any other state; a large RAM-backed buffer would not be.
      for (int i = 0; i < NHIST; i++) hist_q[i] <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
`ifdef RR_STATS_OUTLIER_REJECT_EN
      outlier_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_zero_q  <= div_zero_d;
      hr_bpm_q    <= hr_bpm_d;
      hr_valid_q  <= hr_valid_d;
      brady_q     <= brady_d;
      tachy_q     <= tachy_d;
      dropped_q   <= dropped_d;
      hist_q      <= hist_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      sum_q       <= sum_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
`ifdef RR_STATS_OUTLIER_REJECT_EN
      outlier_q   <= outlier_d;
`endif
    end
  end

  assign o_hr_bpm       = hr_bpm_q;
  assign o_hr_valid     = hr_valid_q;
  assign o_brady        = brady_q;
  assign o_tachy        = tachy_q;
  assign o_dropped      = dropped_q;
  assign o_rr_avg       = avg_q;
  assign o_rr_avg_valid = avg_valid_q;
  assign o_busy         = div_busy || (state_q == ST_DONE);
`ifdef RR_STATS_OUTLIER_REJECT_EN
  assign o_outlier      = outlier_q;
`endif

endmodule
